// File: rtl/leaderboard_pkg.sv
`default_nettype none
// ============================================================================
// leaderboard_pkg : shared types, button indices and field helpers
// Rev 1.0
// ============================================================================
package leaderboard_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISPLAY = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int BTN_NEXT    = 0;
  localparam int BTN_PREV    = 1;
  localparam int BTN_RESTART = 2;

  localparam int MAX_FIELD_W = 64;
  typedef logic [MAX_FIELD_W-1:0]   field_t;
  typedef logic [2*MAX_FIELD_W-1:0] word_t;

  function automatic field_t low_mask(input int unsigned w);
    return (w >= MAX_FIELD_W) ? '1 : ((field_t'(1) << w) - field_t'(1));
  endfunction

  // All-ones score marks end of stream.
  function automatic field_t eos_marker(input int unsigned score_w);
    return low_mask(score_w);
  endfunction

  function automatic field_t score_of(input word_t word, input int unsigned score_w);
    return field_t'(word) & low_mask(score_w);
  endfunction

  function automatic field_t id_of(input word_t word, input int unsigned score_w,
                                   input int unsigned id_w);
    return field_t'(word >> score_w) & low_mask(id_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/leaderboard_insert.sv
`default_nettype none
// ============================================================================
// leaderboard_insert : priority compare giving the insertion shift mask
// Rev 1.0
// ============================================================================
module leaderboard_insert #(
  parameter int DEPTH   = 3,
  parameter int SCORE_W = 16
) (
  input  logic [DEPTH-1:0]              slot_valid,
  input  logic [DEPTH-1:0][SCORE_W-1:0] slot_score,
  input  logic [SCORE_W-1:0]            new_score,
  output logic [DEPTH-1:0]              shift_mask,
  output logic                          accept
);

  logic found;

  // Once the first empty or strictly-lower slot is seen, every later slot moves.
  always_comb begin
    found      = 1'b0;
    shift_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      found         = found | ~slot_valid[i] | (new_score > slot_score[i]);
      shift_mask[i] = found;
    end
  end

  assign accept = shift_mask[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/leaderboard_topn.sv
`default_nettype none
// ============================================================================
// leaderboard_topn : sorted top-DEPTH score table with button paging
// Rev 1.0
// ============================================================================
module leaderboard_topn
  import leaderboard_pkg::*;
#(
  parameter int DEPTH   = 3,
  parameter int ID_W    = 16,
  parameter int SCORE_W = 16,
  parameter int IDX_W   = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [ID_W+SCORE_W-1:0] in_data,
  output logic                    in_ready,
  input  logic [2:0]              buttons,
  output logic                    out_valid,
  output logic [ID_W+SCORE_W-1:0] userid_score_output,
  output logic [IDX_W-1:0]        out_rank,
  output logic [IDX_W-1:0]        entry_count,
  output logic                    scoreboard_eof
);

  localparam int DW = ID_W + SCORE_W;

  state_t                      state, next_state;
  logic [2:0]                  btn_q, btn_rise;
  logic                        restart, go_next, go_prev;
  logic                        transfer, is_eos, accept, table_clear;
  logic [DEPTH-1:0][DW-1:0]    slot_data, shifted_data;
  logic [DEPTH-1:0][SCORE_W-1:0] slot_score;
  logic [DEPTH-1:0]            slot_valid, shifted_valid, shift_mask, ins_at;
  logic [IDX_W-1:0]            rank, next_rank, count;
  logic [DW-1:0]               sel_data;
  logic                        show_entry;

  assign btn_rise    = buttons & ~btn_q;
  assign restart     = btn_rise[BTN_RESTART];
  assign go_next     = btn_rise[BTN_NEXT] & ~btn_rise[BTN_PREV];
  assign go_prev     = btn_rise[BTN_PREV] & ~btn_rise[BTN_NEXT];
  assign in_ready    = (state == ST_COLLECT);
  assign transfer    = in_valid & in_ready;
  assign is_eos      = (score_of(word_t'(in_data), SCORE_W) == eos_marker(SCORE_W));
  assign out_rank    = rank;
  assign entry_count = count;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_score[i] = slot_data[i][SCORE_W-1:0];
    if (i == 0) begin : g_head
      assign ins_at[i]        = shift_mask[i];
      assign shifted_data[i]  = '0;
      assign shifted_valid[i] = 1'b0;
    end else begin : g_body
      assign ins_at[i]        = shift_mask[i] & ~shift_mask[i-1];
      assign shifted_data[i]  = slot_data[i-1];
      assign shifted_valid[i] = slot_valid[i-1];
    end
  end

  leaderboard_insert #(
    .DEPTH   (DEPTH),
    .SCORE_W (SCORE_W)
  ) u_insert (
    .slot_valid (slot_valid),
    .slot_score (slot_score),
    .new_score  (in_data[SCORE_W-1:0]),
    .shift_mask (shift_mask),
    .accept     (accept)
  );

  always_comb begin
    next_state  = state;
    next_rank   = rank;
    table_clear = 1'b0;
    if (restart) begin
      next_state  = ST_CLEAR;
      table_clear = 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          next_state  = ST_COLLECT;
          table_clear = 1'b1;
        end
        ST_COLLECT: begin
          if (transfer && is_eos) begin
            next_state = ST_DISPLAY;
            next_rank  = '0;
          end
        end
        ST_DISPLAY: begin
          if (count == '0) begin
            next_state = ST_DONE;
          end else if (go_next) begin
            if (rank + IDX_W'(1) < count) next_rank = rank + IDX_W'(1);
            else                          next_state = ST_DONE;
          end else if (go_prev && rank != '0) begin
            next_rank = rank - IDX_W'(1);
          end
        end
        ST_DONE:  next_state = ST_DONE;
        default:  next_state = ST_CLEAR;
      endcase
    end
    if (next_state == ST_CLEAR) next_rank = '0;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (next_rank == IDX_W'(i)) sel_data = slot_data[i];
    end
  end

  assign show_entry = (next_state == ST_DISPLAY) && (next_rank < count);

  always_ff @(posedge clk) begin
    if (!rst || table_clear) begin
      slot_data  <= '0;
      slot_valid <= '0;
      count      <= '0;
    end else if (transfer && !is_eos && accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (shift_mask[i]) begin
          slot_data[i]  <= ins_at[i] ? in_data : shifted_data[i];
          slot_valid[i] <= ins_at[i] | shifted_valid[i];
        end
      end
      if (count != IDX_W'(DEPTH)) count <= count + IDX_W'(1);
    end
  end

  // Outputs are registered from the next-state view so they line up with state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= ST_CLEAR;
      rank                <= '0;
      btn_q               <= '0;
      out_valid           <= 1'b0;
      userid_score_output <= '0;
      scoreboard_eof      <= 1'b0;
    end else begin
      state               <= next_state;
      rank                <= next_rank;
      btn_q               <= buttons;
      out_valid           <= show_entry;
      userid_score_output <= show_entry ? sel_data : '0;
      scoreboard_eof      <= (next_state == ST_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leaderboard_topn.sv
`default_nettype none
// ============================================================================
// tb_leaderboard_topn : randomized + directed bench with a queue-based model
// Rev 1.0
// ============================================================================
module tb_leaderboard_topn;

  localparam int DEPTH   = 3;
  localparam int ID_W    = 16;
  localparam int SCORE_W = 16;
  localparam int IDX_W   = $clog2(DEPTH + 1);
  localparam int DW      = ID_W + SCORE_W;

  localparam int M_CLEAR = 0, M_COLLECT = 1, M_DISPLAY = 2, M_DONE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic [2:0]        buttons = '0;
  logic              in_ready, out_valid, scoreboard_eof;
  logic [DW-1:0]     userid_score_output;
  logic [IDX_W-1:0]  out_rank, entry_count;

  int   total = 0;
  int   bad   = 0;
  logic cmp_en = 1'b0;

  // Reference model: ranked list kept as a queue, highest score first.
  logic [DW-1:0] mtab[$];
  int            m_mode = M_CLEAR;
  int            m_rank = 0;
  logic [2:0]    m_btn_q = '0;
  logic          e_ready = 1'b0, e_valid = 1'b0, e_eof = 1'b0;
  logic [DW-1:0] e_data = '0;
  int            e_rank = 0, e_count = 0;

  leaderboard_topn #(
    .DEPTH(DEPTH), .ID_W(ID_W), .SCORE_W(SCORE_W), .IDX_W(IDX_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .buttons             (buttons),
    .out_valid           (out_valid),
    .userid_score_output (userid_score_output),
    .out_rank            (out_rank),
    .entry_count         (entry_count),
    .scoreboard_eof      (scoreboard_eof)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_insert(input logic [DW-1:0] w);
    int            k;
    logic          found;
    logic [DW-1:0] cur;
    k     = mtab.size();
    found = 1'b0;
    for (int i = 0; i < mtab.size(); i++) begin
      cur = mtab[i];
      if (!found && (w[SCORE_W-1:0] > cur[SCORE_W-1:0])) begin
        k     = i;
        found = 1'b1;
      end
    end
    mtab.insert(k, w);
    if (mtab.size() > DEPTH) void'(mtab.pop_back());
  endtask

  task automatic step_model();
    logic [2:0] rise;
    if (!rst) begin
      m_mode  = M_CLEAR;
      mtab.delete();
      m_rank  = 0;
      m_btn_q = '0;
    end else begin
      rise    = buttons & ~m_btn_q;
      m_btn_q = buttons;
      if (rise[2]) begin
        m_mode = M_CLEAR;
        mtab.delete();
        m_rank = 0;
      end else begin
        case (m_mode)
          M_CLEAR:   m_mode = M_COLLECT;
          M_COLLECT: begin
            if (in_valid) begin
              if (in_data[SCORE_W-1:0] == {SCORE_W{1'b1}}) m_mode = M_DISPLAY;
              else                                      model_insert(in_data);
            end
          end
          M_DISPLAY: begin
            if (mtab.size() == 0) m_mode = M_DONE;
            else if (rise[0] && !rise[1]) begin
              if (m_rank + 1 < mtab.size()) m_rank++;
              else                          m_mode = M_DONE;
            end else if (rise[1] && !rise[0] && m_rank > 0) m_rank--;
          end
          default: ;
        endcase
      end
    end
    e_ready = (m_mode == M_COLLECT);
    e_count = mtab.size();
    e_valid = (m_mode == M_DISPLAY) && (m_rank < mtab.size());
    e_data  = e_valid ? mtab[m_rank] : '0;
    e_rank  = m_rank;
    e_eof   = (m_mode == M_DONE);
  endtask

  initial forever begin
    @(posedge clk);
    step_model();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("in_ready",    32'(in_ready),            32'(e_ready));
      chk("entry_count", 32'(entry_count),         32'(e_count));
      chk("out_valid",   32'(out_valid),           32'(e_valid));
      chk("out_data",    32'(userid_score_output), 32'(e_data));
      chk("out_rank",    32'(out_rank),            32'(e_rank));
      chk("eof",         32'(scoreboard_eof),      32'(e_eof));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ID_W-1:0] id, input logic [SCORE_W-1:0] score);
    in_data  = {id, score};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic press(input int b);
    buttons[b] = 1'b1;
    tick();
    buttons[b] = 1'b0;
    tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!e_ready && n < 20) begin
      tick();
      n++;
    end
    if (!e_ready) chk("wait_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic restart_round();
    press(2);
    wait_ready();
  endtask

  initial begin
    repeat (3) tick();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(entry_count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    wait_ready();

    // Sort and discard: 5,9,7,2 -> 9,7,5
    send(16'h0A05, 16'd5); send(16'h0B09, 16'd9);
    send(16'h0C07, 16'd7); send(16'h0D02, 16'd2);
    send(16'h0000, 16'hFFFF);
    tick(); tick();
    @(negedge clk);
    chk("sort_count", 32'(entry_count), 32'd3);
    chk("sort_rank0", 32'(userid_score_output), 32'h0B09_0009);
    press(0);
    @(negedge clk);
    chk("sort_rank1", 32'(userid_score_output), 32'h0C07_0007);
    press(0);
    @(negedge clk);
    chk("sort_rank2", 32'(userid_score_output), 32'h0A05_0005);
    press(0);
    @(negedge clk);
    chk("paged_eof", 32'(scoreboard_eof), 32'd1);
    chk("paged_data", 32'(userid_score_output), 32'd0);

    // Ties keep arrival order; score 0 fills an empty slot
    restart_round();
    send(16'h00A0, 16'd4); send(16'h00B0, 16'd4); send(16'h00C0, 16'd0);
    send(16'h0000, 16'hFFFF);
    tick();
    @(negedge clk);
    chk("tie_rank0", 32'(userid_score_output), 32'h00A0_0004);
    chk("tie_count", 32'(entry_count), 32'd3);
    press(0);
    @(negedge clk);
    chk("tie_rank1", 32'(userid_score_output), 32'h00B0_0004);

    // EOS as first word
    restart_round();
    send(16'h0055, 16'hFFFF);
    tick(); tick();
    @(negedge clk);
    chk("empty_eof", 32'(scoreboard_eof), 32'd1);
    chk("empty_valid", 32'(out_valid), 32'd0);

    // Holding next advances once; prev floors at 0; next+prev together ignored
    restart_round();
    send(16'h0001, 16'd30); send(16'h0002, 16'd20); send(16'h0003, 16'd10);
    send(16'h0000, 16'hFFFF);
    buttons[0] = 1'b1;
    repeat (10) tick();
    buttons[0] = 1'b0;
    tick();
    @(negedge clk);
    chk("hold_rank", 32'(out_rank), 32'd1);
    chk("hold_data", 32'(userid_score_output), 32'h0002_0014);
    press(1); press(1);
    @(negedge clk);
    chk("prev_floor", 32'(userid_score_output), 32'h0001_001E);
    press(0);
    buttons[1:0] = 2'b11;
    tick();
    buttons[1:0] = 2'b00;
    tick();
    @(negedge clk);
    chk("both_rank", 32'(out_rank), 32'd1);

    // Mid-stream restart
    restart_round();
    send(16'h0011, 16'd3); send(16'h0012, 16'd8);
    buttons[2] = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_count", 32'(entry_count), 32'd0);
    chk("mid_ready_low", 32'(in_ready), 32'd0);
    buttons[2] = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_ready_high", 32'(in_ready), 32'd1);
    send(16'h0021, 16'd6); send(16'h0022, 16'd8); send(16'h0023, 16'd1);
    send(16'h0000, 16'hFFFF);
    tick();
    @(negedge clk);
    chk("mid_rank0", 32'(userid_score_output), 32'h0022_0008);

    // Reset during DISPLAY
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_count", 32'(entry_count), 32'd0);
    rst = 1'b1;
    tick();

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      int n;
      restart_round();
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        send(16'($urandom), 16'($urandom_range(0, 12)));
        repeat ($urandom_range(0, 2)) tick();
      end
      send(16'($urandom), 16'hFFFF);
      for (int k = 0; k < 8; k++) begin
        buttons[1:0] = 2'($urandom_range(0, 3));
        repeat ($urandom_range(1, 3)) tick();
        buttons[1:0] = 2'b00;
        tick();
      end
    end

    tick();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
